// File: rtl/grf.sv
// General register file: 32 x 32-bit, $0 hardwired to zero, two combinational read ports,
// one write port. Optional same-cycle write-to-read forwarding when GRF_BYPASS_EN is defined.
module grf #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWrite,
  input  logic [4:0]      A3,
  input  logic [DW-1:0]   WD,
  input  logic [31:0]     WPC,
  input  logic [4:0]      A1,
  input  logic [4:0]      A2,
  output logic [DW-1:0]   RD1,
  output logic [DW-1:0]   RD2,
  output logic [CNTW-1:0] wr_cnt
);

  logic [DW-1:0]   regs_q [NREG];
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            wrEn;
  logic [DW-1:0]   rd1Arr, rd2Arr;

  // A write to $0 is not a commit: no state change, no count, no trace.
  assign wrEn = RegWrite && (A3 != 5'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (wrEn) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      if (wrEn) begin
        regs_q[A3] <= WD;
      end
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    rd1Arr = (A1 == 5'd0) ? '0 : regs_q[A1];
    rd2Arr = (A2 == 5'd0) ? '0 : regs_q[A2];
`ifdef GRF_BYPASS_EN
    // Forward the in-flight write so D sees W's result without a hazard-unit path.
    RD1 = (wrEn && (A1 == A3)) ? WD : rd1Arr;
    RD2 = (wrEn && (A2 == A3)) ? WD : rd2Arr;
`else
    RD1 = rd1Arr;
    RD2 = rd2Arr;
`endif
  end

  assign wr_cnt = cnt_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && wrEn) begin
      $display("@%h: $%d <= %h", WPC, A3, WD);
    end
  end
`endif

endmodule

// File: tb/tb_grf.sv
// Self-checking bench for grf: directed cases plus randomized traffic against an
// array-based reference model of the register file and its commit counter.
module tb_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  A3, A1, A2;
  logic [31:0] WD, WPC, RD1, RD2, wr_cnt;

  logic [31:0] model [32];
  logic [31:0] modelCnt;
  int          errors = 0;
  int          checks = 0;
  bit          bypass;

  always #5 clk = ~clk;

  grf dut (
    .clk      (clk),
    .reset    (reset),
    .RegWrite (RegWrite),
    .A3       (A3),
    .WD       (WD),
    .WPC      (WPC),
    .A1       (A1),
    .A2       (A2),
    .RD1      (RD1),
    .RD2      (RD2),
    .wr_cnt   (wr_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Expected read value from the architectural view of the register file
  function automatic logic [31:0] expRead(input logic [4:0] a);
    if (bypass && RegWrite && (A3 != 5'd0) && (a == A3)) return WD;
    if (a == 5'd0) return 32'd0;
    return model[a];
  endfunction

  task automatic applyStimulus(input string tag, input logic rst, input logic we,
                               input logic [4:0] a3, input logic [31:0] wd,
                               input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    reset    = rst;
    RegWrite = we;
    A3       = a3;
    WD       = wd;
    A1       = a1;
    A2       = a2;
    WPC      = $urandom;
    #1;
    checkOutput({tag, "/rd1_pre"}, RD1, expRead(A1));
    checkOutput({tag, "/rd2_pre"}, RD2, expRead(A2));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      modelCnt = 32'd0;
    end else if (we && (a3 != 5'd0)) begin
      model[a3] = wd;
      modelCnt  = modelCnt + 32'd1;
    end
    #1;
    checkOutput({tag, "/rd1_post"}, RD1, expRead(A1));
    checkOutput({tag, "/rd2_post"}, RD2, expRead(A2));
    checkOutput({tag, "/wr_cnt"}, wr_cnt, modelCnt);
  endtask

  initial begin
`ifdef GRF_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    modelCnt = 32'd0;

    reset = 1'b1; RegWrite = 1'b0; A3 = '0; WD = '0; A1 = '0; A2 = '0; WPC = '0;
    @(posedge clk);
    #1;
    checkOutput("init/wr_cnt", wr_cnt, 32'd0);
    checkOutput("init/rd1", RD1, 32'd0);

    // Reset clears earlier writes
    applyStimulus("t1_wr",    1'b0, 1'b1, 5'd5, 32'h0000_1234, 5'd5, 5'd0);
    applyStimulus("t1_rst",   1'b1, 1'b0, 5'd0, 32'h0,         5'd5, 5'd5);
    applyStimulus("t1_rd",    1'b0, 1'b0, 5'd0, 32'h0,         5'd5, 5'd5);
    checkOutput("t1/rd1_zero", RD1, 32'd0);

    // Basic write/read
    applyStimulus("t2_wr",    1'b0, 1'b1, 5'd8, 32'hDEAD_BEEF, 5'd1, 5'd2);
    applyStimulus("t2_rd",    1'b0, 1'b0, 5'd0, 32'h0,         5'd8, 5'd8);
    checkOutput("t2/rd1", RD1, 32'hDEAD_BEEF);
    checkOutput("t2/cnt", wr_cnt, 32'd1);

    // $0 stays zero and does not count
    applyStimulus("t3_wr0",   1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    checkOutput("t3/cnt", wr_cnt, 32'd1);

    // Same-cycle read of the register being written
    applyStimulus("t4_setup", 1'b0, 1'b1, 5'd9, 32'h0000_0011, 5'd0, 5'd0);
    applyStimulus("t4_haz",   1'b0, 1'b1, 5'd9, 32'h0000_0022, 5'd9, 5'd9);
    checkOutput("t4/rd1_after", RD1, 32'h0000_0022);

    // Masked write
    applyStimulus("t5_setup", 1'b0, 1'b1, 5'd3, 32'h0000_00AA, 5'd0, 5'd0);
    applyStimulus("t5_mask",  1'b0, 1'b0, 5'd3, 32'h0000_0055, 5'd3, 5'd3);
    checkOutput("t5/rd1", RD1, 32'h0000_00AA);

    // Reset wins over a colliding write
    applyStimulus("t6_coll",  1'b1, 1'b1, 5'd4, 32'h0000_0077, 5'd1, 5'd2);
    applyStimulus("t6_rd",    1'b0, 1'b0, 5'd0, 32'h0,         5'd4, 5'd9);
    checkOutput("t6/rd1", RD1, 32'd0);
    checkOutput("t6/cnt", wr_cnt, 32'd0);

    // Randomized traffic; small address range on some cycles to provoke hazards
    for (int n = 0; n < 400; n++) begin
      logic        rst, we;
      logic [4:0]  a3, a1, a2;
      logic [31:0] wd;
      rst = ($urandom_range(0, 59) == 0);
      we  = ($urandom_range(0, 3) != 0);
      a3  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        a1 = 5'($urandom_range(0, 3));
        a2 = 5'($urandom_range(0, 3));
        a3 = 5'($urandom_range(0, 3));
      end else begin
        a1 = 5'($urandom_range(0, 31));
        a2 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      end
      applyStimulus("rand", rst, we, a3, wd, a1, a2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
